// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// pc_sequencer_if : fetch/execute handshake and branch-control bundle
// Rev 1.0
// ============================================================================
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic        exec_done;
  logic        branch;
  logic [2:0]  brcond;
  logic        blop;
  logic        br_reg;
  logic [31:0] offset;
  logic [31:0] rs_val;
  logic        flag_we;
  logic        carry_in;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_data;
  logic        busy;

  // Sequencer side
  modport master (
    output imem_req, imem_addr, pc, link_we, link_data, busy,
    input  imem_valid, exec_done, branch, brcond, blop, br_reg,
           offset, rs_val, flag_we, carry_in
  );

  // Memory/datapath side
  modport slave (
    input  imem_req, imem_addr, pc, link_we, link_data, busy,
    output imem_valid, exec_done, branch, brcond, blop, br_reg,
           offset, rs_val, flag_we, carry_in
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : IDLE/FETCH/EXEC program-counter sequencer with branches,
//                branch-and-link and a carry flag.   Rev 1.0
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [2:0] c_br_always = 3'd1;
  localparam logic [2:0] c_br_ltz    = 3'd2;
  localparam logic [2:0] c_br_z      = 3'd3;
  localparam logic [2:0] c_br_nz     = 3'd4;
  localparam logic [2:0] c_br_cy     = 3'd5;
  localparam logic [2:0] c_br_ncy    = 3'd6;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        carry_q, carry_d;
  logic        link_we_q, link_we_d;
  logic [31:0] link_data_q, link_data_d;
  logic        imem_req_q, imem_req_d;
  logic        busy_q, busy_d;

  logic        cond;
  logic        taken;
  logic        retire;
  logic [31:0] pc_plus4;
  logic [31:0] pc_rel;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_rel   = pc_q + (bus.offset << 2);
  assign retire   = (state_q == S_EXEC) && bus.exec_done;

  // Condition uses the carry held before any same-cycle flag update.
  always_comb begin
    cond = 1'b0;
    case (bus.brcond)
      c_br_always: cond = 1'b1;
      c_br_ltz:    cond = bus.rs_val[31];
      c_br_z:      cond = (bus.rs_val == 32'd0);
      c_br_nz:     cond = (bus.rs_val != 32'd0);
      c_br_cy:     cond = carry_q;
      c_br_ncy:    cond = ~carry_q;
      default:     cond = 1'b0;
    endcase
    taken = bus.branch & cond;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    carry_d     = carry_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.imem_valid) state_d = S_EXEC;
      S_EXEC:  if (bus.exec_done)  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      if (taken && bus.br_reg) begin
        pc_d = bus.rs_val;
      end else if (taken) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_plus4;
      end
      if (bus.branch && bus.blop) begin
        link_we_d   = 1'b1;
        link_data_d = pc_plus4;
      end
      if (bus.flag_we) begin
        carry_d = bus.carry_in;
      end
    end

    imem_req_d = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      carry_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= 32'd0;
      imem_req_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      carry_q     <= carry_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      imem_req_q  <= imem_req_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.link_we   = link_we_q;
  assign bus.link_data = link_data_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, 32'h0000_0000, byte address loaded into pc on reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch byte address; equals pc.
REQ-007 imem_valid  in  1  instruction word available this cycle.
REQ-008 exec_done  in  1  datapath finished the current instruction; all inputs below are sampled only when it is high.
REQ-009 branch  in  1  instruction is a branch (decoder Branch output).
REQ-010 brcond  in  3  branch condition (decoder ALUop[2:0]):
- 1 = always
- 2 = ltz
- 3 = z
- 4 = nz
- 5 = cy
- 6 = ncy
- 0 and 7 = never.
REQ-011 blop  in  1  branch-and-link (decoder BLop).
REQ-012 br_reg  in  1  register-indirect target (br).
REQ-013 offset  in  32  sign-extended word offset.
REQ-014 rs_val  in  32  source register value.
REQ-015 flag_we  in  1  update the carry flag.
REQ-016 carry_in  in  1  ALU carry-out.
REQ-017 pc  out  32  current program counter.
REQ-018 link_we  out  1  one-cycle write strobe for the link register.
REQ-019 link_data  out  32  return address.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 The block SHALL implement FSM states IDLE, FETCH and EXEC.
- Transitions: IDLE->FETCH unconditionally; FETCH->EXEC when imem_valid=1; EXEC->FETCH when exec_done=1.
- Otherwise the state SHALL hold.
REQ-022 imem_req SHALL be 1 exactly in FETCH.
REQ-023 imem_addr SHALL equal pc combinationally in every state.
REQ-024 imem_valid SHALL be ignored outside FETCH.
REQ-025 exec_done SHALL be ignored outside EXEC.
REQ-026 Branch decision taken SHALL be branch AND cond, where cond is:
- always: 1
- ltz: rs_val[31]
- z: rs_val==0
- nz: rs_val!=0
- cy: carry
- ncy: !carry
- codes 0 and 7: 0.
REQ-027 On the EXEC cycle with exec_done=1, pc SHALL load on the next edge:
- rs_val, if taken and br_reg=1;
- pc + (offset<<2), if taken and br_reg=0 (modulo 2^32);
- pc + 4 otherwise (modulo 2^32).
REQ-028 An instruction with branch=0 SHALL always advance pc by 4, regardless of brcond.
REQ-029 link_we SHALL be 1 for exactly the one cycle after the exec_done edge when branch=1 and blop=1 (condition irrelevant for bl; its brcond is 1).
REQ-030 link_data SHALL hold the old pc+4, registered on that same edge, and SHALL be stable while link_we=1.
REQ-031 The carry register SHALL load carry_in on the exec_done edge when flag_we=1.
REQ-032 A branch evaluated in the same cycle as flag_we SHALL use the carry value held before the update.
REQ-033 pc wrap-around SHALL be silent; no overflow indication.
REQ-034 Latency SHALL be a minimum of 2 cycles per instruction: 1 FETCH + 1 EXEC. Each wait cycle adds one.
REQ-035 Inputs that change while not sampled SHALL have no effect on pc, carry, link_we or link_data.

Reset
REQ-036 When reset=1 at a clock edge, the block SHALL set:
- state=IDLE
- pc=RESET_PC
- carry=0
- link_we=0
- link_data=0
- imem_req=0
- busy=0.
REQ-037 reset SHALL override any concurrent imem_valid or exec_done, including mid-FETCH or mid-EXEC.
REQ-038 After reset, no pc or link update from an aborted instruction SHALL occur.
REQ-039 The first fetch SHALL assert imem_req with imem_addr=RESET_PC on the second edge after reset deasserts.

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
- Sequential: reset, imem_valid every FETCH, exec_done with branch=0, three instructions -> imem_addr 0x0, 0x4, 0x8, 0xC; each instruction 2 cycles.
- bl: pc=0x10, branch=1, blop=1, brcond=1, offset=0x3 -> pc=0x1C; link_we high 1 cycle; link_data=0x14.
- bcy ordering: carry=0; on one exec_done, flag_we=1, carry_in=1, branch=1, brcond=5 -> not taken (pc+4). Next bcy -> taken.
- br and bz: br_reg=1, rs_val=0x100 -> pc=0x100. bz with rs_val=0 and offset=-2 from pc=0x100 -> pc=0xF8. bz with rs_val=5 -> pc=0x104.
- Stall/reset: imem_valid held low 5 cycles (imem_req stays 1, pc unchanged). Then reset asserted in EXEC with exec_done=1 -> pc=RESET_PC, link_we=0, state IDLE.
